mem_bus_arbiter: RTL

- Shares the single unified memory port between two bus masters.
  - Master 0 is the multicycle core, doing instruction fetch and load/store.
  - Master 1 is a secondary master: the debug/program loader or DMA.
- Round-robin arbitration, one outstanding transaction at a time.
- Request fields are registered at grant.
- A wait-state timeout returns an error response instead of hanging the core FSM.

---
 rtl/bus_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and
// master index constants used by the arbiter and its round-robin picker.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic MASTER_CORE = 1'b0;
    localparam logic MASTER_AUX  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin picker.
// Ports: req_i[1:0] requests, last_grant_i previous winner,
//        gnt_o winning index, valid_o at least one request present.
module rr_arbiter2
    import bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        gnt_o   = MASTER_CORE;
        unique case (req_i)
            2'b01:   gnt_o = MASTER_CORE;
            2'b10:   gnt_o = MASTER_AUX;
            // On a tie the master that did not win last time goes first.
            2'b11:   gnt_o = ~last_grant_i;
            default: gnt_o = MASTER_CORE;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the core (m0) and an auxiliary master
// (m1): round-robin grant, one transaction in flight, request fields
// registered at grant, and a wait-state timeout that answers with err.
// Ports: clk/reset (sync, active-high); m0_*/m1_* master request side
// (req/we/addr/wdata in, rdata/ack/err out); mem_* memory side
// (req/we/addr/wdata out, rdata/ack in).
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    state_t                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic [CW-1:0]         wait_cnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  pick_gnt;
    logic                  pick_vld;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    rr_arbiter2 u_rr (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .gnt_o        (pick_gnt),
        .valid_o      (pick_vld)
    );

    always_comb begin
        we_d    = m0_we;
        addr_d  = m0_addr;
        wdata_d = m0_wdata;
        if (pick_gnt == MASTER_AUX) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= MASTER_CORE;
            last_grant_q <= MASTER_AUX;
            wait_cnt_q   <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q      <= pick_gnt;
                        last_grant_q <= pick_gnt;
                        we_q         <= we_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        wait_cnt_q   <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // A real ack wins over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic resp;
    assign resp = (state_q == RESP);

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign m0_ack   = resp && (owner_q == MASTER_CORE);
    assign m0_err   = m0_ack && err_q;
    assign m0_rdata = m0_ack ? rdata_q : '0;

    assign m1_ack   = resp && (owner_q == MASTER_AUX);
    assign m1_err   = m1_ack && err_q;
    assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule
